// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer, status and drain/flush controller of the
// asynchronous FIFO. Lives entirely in clk_r and works from the already
// synchronized Gray write pointer.
module fifo_rd_ctrl #(
    parameter  int depth  = 1024,
    parameter  int ae_lvl = 4,
    localparam int AW     = $clog2(depth)
) (
    input  logic          clk_r,
    input  logic          rst_r,
    input  logic          rd_en,
    input  logic [AW:0]   wptr_gray_sync,
    input  logic          drain,
    input  logic [AW-1:0] marker,
    output logic [AW-1:0] raddr,
    output logic [AW-1:0] rptr,
    output logic [AW:0]   rptr_gray,
    output logic          rd_valid,
    output logic          empty,
    output logic          almost_empty,
    output logic [AW:0]   rd_count,
    output logic          underflow,
    output logic          drain_done
);

    // Occupancy can never exceed depth, so a larger threshold simply means
    // "always almost empty"; clamping keeps the constant inside AW+1 bits.
    localparam int          AE_CLAMP = (ae_lvl > depth) ? depth : ae_lvl;
    localparam logic [AW:0] AE_THR   = (AW+1)'(AE_CLAMP);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [AW:0] rbin_reg;
    logic [AW:0] rbin_next;
    logic [AW:0] rgray_reg;
    logic [AW:0] rgray_next;

    logic        empty_reg;
    logic        empty_next;
    logic        almost_empty_reg;
    logic        almost_empty_next;
    logic [AW:0] rd_count_reg;
    logic [AW:0] rd_count_next;
    logic        rd_valid_reg;
    logic        underflow_reg;
    logic        underflow_next;
    logic        drain_done_reg;
    logic        drain_done_next;

    logic [AW:0] wbin;
    logic [AW:0] count_calc;
    logic        drain_hold;
    logic        read_phase;
    logic        acc;
    logic        force_empty;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    // Written as a reduction per bit so there is no bit-to-bit combinational chain.
    for (genvar gi = 0; gi <= AW; gi++) begin : g_gray2bin
        assign wbin[gi] = ^wptr_gray_sync[AW:gi];
    end

    // A drain parks at the marker address: reads there are withheld, not errors.
    assign drain_hold = (state_reg == DRAIN) && (rbin_reg[AW-1:0] == marker);
    assign read_phase = (state_reg == RUN) || (state_reg == DRAIN);
    assign acc        = rd_en && !empty_reg && read_phase && !drain_hold;

    // Next-state, next-pointer and flush actions of the read controller.
    always_comb begin
        state_next      = state_reg;
        rbin_next       = rbin_reg;
        force_empty     = 1'b0;
        drain_done_next = 1'b0;

        if (acc) begin
            rbin_next = rbin_reg + PTR_ONE;
        end

        case (state_reg)
            RUN: begin
                if (drain) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_hold && !acc) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // Pointers return to zero so both domains restart from a clean origin.
                rbin_next       = '0;
                force_empty     = 1'b1;
                drain_done_next = 1'b1;
                state_next      = WAIT0;
            end
            WAIT0: begin
                // Hold off until the write side has also been cleared and the
                // marker logic has dropped its request.
                force_empty = 1'b1;
                if ((wptr_gray_sync == '0) && !drain) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Status is derived from the next pointer so the read that empties the
    // FIFO raises empty on the same edge it is accepted.
    always_comb begin
        rgray_next     = rbin_next ^ (rbin_next >> 1);
        count_calc     = wbin - rbin_next;
        underflow_next = underflow_reg | (rd_en & ~acc & ~drain_hold);

        if (force_empty) begin
            empty_next        = 1'b1;
            rd_count_next     = '0;
            almost_empty_next = 1'b1;
        end else begin
            empty_next        = (rgray_next == wptr_gray_sync);
            rd_count_next     = count_calc;
            almost_empty_next = (count_calc <= AE_THR);
        end
    end

    // State register for the FSM.
    always_ff @(posedge clk_r or posedge rst_r) begin
        if (rst_r) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Pointer registers; Gray copy is registered so it crosses domains glitch-free.
    always_ff @(posedge clk_r or posedge rst_r) begin
        if (rst_r) begin
            rbin_reg  <= '0;
            rgray_reg <= '0;
        end else begin
            rbin_reg  <= rbin_next;
            rgray_reg <= rgray_next;
        end
    end

    // Status, data-valid and event flags.
    always_ff @(posedge clk_r or posedge rst_r) begin
        if (rst_r) begin
            empty_reg        <= 1'b1;
            almost_empty_reg <= 1'b1;
            rd_count_reg     <= '0;
            rd_valid_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
            drain_done_reg   <= 1'b0;
        end else begin
            empty_reg        <= empty_next;
            almost_empty_reg <= almost_empty_next;
            rd_count_reg     <= rd_count_next;
            rd_valid_reg     <= acc;
            underflow_reg    <= underflow_next;
            drain_done_reg   <= drain_done_next;
        end
    end

    assign raddr        = rbin_reg[AW-1:0];
    assign rptr         = rbin_reg[AW-1:0];
    assign rptr_gray    = rgray_reg;
    assign rd_valid     = rd_valid_reg;
    assign empty        = empty_reg;
    assign almost_empty = almost_empty_reg;
    assign rd_count     = rd_count_reg;
    assign underflow    = underflow_reg;
    assign drain_done   = drain_done_reg;

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-domain pointer and status controller for the asynchronous FIFO. Runs entirely in the read clock domain and consumes the synchronized Gray write pointer. Produces the read address, the Gray/binary read pointers, and the empty, almost-empty and occupancy status. It also drives the drain/flush sequence requested by the reset-marker logic: after a write-side reset, reads continue up to the marked address, then the read pointers return to zero.

## Interface
Parameters:
- depth, 1024: FIFO depth in words; power of two, ≥4. AW = $clog2(depth).
- ae_lvl, 4: almost_empty asserts when occupancy ≤ ae_lvl.

Ports:
- clk_r  in  1  read-domain clock; all state changes on its rising edge.
- rst_r  in  1  reset, asynchronous and active-high.
- rd_en  in  1  read request.
- wptr_gray_sync  in  AW+1  write pointer, Gray coded, already 2-FF synchronized into clk_r.
- drain  in  1  level from the marker logic; high requests drain-to-marker.
- marker  in  AW  first address NOT to be read during a drain.
- raddr  out  AW  RAM read address, equal to rbin[AW-1:0].
- rptr  out  AW  binary read address, for the marker comparison; same value as raddr.
- rptr_gray  out  AW+1  registered Gray read pointer, for synchronizing into the write domain.
- rd_valid  out  1  RAM read data valid this cycle.
- empty  out  1  FIFO empty.
- almost_empty  out  1  occupancy ≤ ae_lvl.
- rd_count  out  AW+1  occupancy as seen from the read side.
- underflow  out  1  sticky error flag.
- drain_done  out  1  single-cycle pulse when the pointers are cleared after a drain.

## Operation
- State: rbin (AW+1 bits) and rgray (AW+1 bits), both registers. rgray = rbin ^ (rbin>>1) at all times.
- wbin = gray2bin(wptr_gray_sync), computed combinationally. Width AW+1; the MSB is the wrap bit.
- A read is accepted (acc) when all of these hold: rd_en=1, empty=0, state is RUN or DRAIN, and if state=DRAIN, rbin[AW-1:0] ≠ marker.
- On acc: rbin_next = rbin+1, modulo 2^(AW+1).
- Status is registered from the next-pointer values:
  - empty <= (gray(rbin_next) == wptr_gray_sync)
  - rd_count <= (wbin − rbin_next) mod 2^(AW+1)
  - almost_empty <= (rd_count_next ≤ ae_lvl)
- underflow is set if rd_en=1 while acc=0 for any reason other than drain_hold (DRAIN with rbin[AW-1:0]==marker). It stays set until rst_r.
- FSM:
  - RUN: normal reads. If drain=1 → DRAIN.
  - DRAIN: reads allowed per acc. When rbin[AW-1:0]==marker and not accepting → FLUSH.
  - FLUSH (1 cycle):
    - rbin, rgray <= 0; empty <= 1; rd_count <= 0; almost_empty <= 1; drain_done <= 1.
    - → WAIT0.
  - WAIT0: no reads; status is held at empty. Go to RUN when wptr_gray_sync==0 and drain=0.
- In WAIT0 the status registers are not recomputed from wptr_gray_sync; they are forced to empty.

## Timing
- Reset values (asynchronous, while rst_r=1):
  - rbin=0, rgray=0, raddr=0, rptr=0, rptr_gray=0
  - empty=1, almost_empty=1, rd_count=0
  - rd_valid=0, underflow=0, drain_done=0
  - state=RUN
- Read latency: the RAM samples raddr at the acc edge. rd_valid=1 in the following cycle, aligned with RAM data.
- Back-to-back reads: one per cycle while empty=0. The read that empties the FIFO sets empty=1 at the same edge.
- Write-visibility latency: a write shows up on wptr_gray_sync 2 clk_r cycles after the write-domain update (external synchronizer). After that, empty deasserts 1 clk_r later.
- Full wrap: rbin MSB toggles every depth reads. rd_count=depth is legal (full as seen from the read side).
- drain=1 and rd_en=1 in the same RUN cycle: the read is accepted and the state enters DRAIN.
- marker equal to the current rbin address on DRAIN entry: no read is accepted and the FSM → FLUSH next cycle.
- drain_done is high for exactly one cycle, the cycle after FLUSH.
- rst_r mid-drain: immediate return to reset values; any pending drain is abandoned.

## Test plan
- Reset, depth=16: hold rst_r=1 → empty=1, almost_empty=1, rd_count=0, rptr_gray=0. Then drive rd_en=1 with FIFO empty → underflow=1 next edge and stays set.
- Drive wptr_gray_sync = gray(5) = 5'b00111, then rd_en=1 for 6 cycles:
  - 5 accepts, raddr 0..4; rd_valid 1 cycle after each.
  - empty=1 after the 5th accept; rd_count sequence 5,4,3,2,1,0.
  - The 6th request sets underflow.
- Wrap, depth=16: run 40 writes/reads interleaved → rptr_gray is a valid Gray sequence, with exactly 1 bit change per accept. rbin MSB toggles at read 16 and read 32. rd_count never exceeds 16.
- Drain: wbin=10, rbin=3, marker=7, drain=1, rd_en held high:
  - Accepts at addresses 3..6 only.
  - FLUSH → rptr=0, drain_done pulse, empty=1.
  - Stays in WAIT0 until wptr_gray_sync=0 and drain=0, then returns to RUN.
- ae_lvl=4, rd_count 6 → reads down to 4 → almost_empty asserts on the edge where rd_count becomes 4.
- Assert rst_r during DRAIN → all outputs return to reset values asynchronously, state=RUN, and no drain_done pulse is produced.
